// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: handshake bundle between NUM_REQ producers, the write
// arbiter and the FIFO memory write port.
//
// Handshake rule: a beat from producer i moves on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_last[i] marks the final
// beat of a packet. winc is high on exactly the cycles a beat moves into
// memory; wdata holds that beat.
//
// Signals:
//   req_valid [NUM_REQ]             producer beat valid
//   req_last  [NUM_REQ]             producer beat is last of packet
//   req_data  [NUM_REQ*FIFO_WIDTH]  producer i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready [NUM_REQ]             beat accepted when valid & ready
//   wfull                           FIFO full, from write-pointer logic
//   winc                            memory write enable / pointer increment
//   wdata     [FIFO_WIDTH]          memory write data
// Modports:
//   master  producers plus write-pointer logic (drive requests and wfull)
//   slave   the arbiter (drives ready, winc, wdata)
interface fifo_wr_arb_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          winc;
    logic [FIFO_WIDTH-1:0]         wdata;

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the FIFO write port among
// NUM_REQ producers. One producer is granted per packet and keeps the grant
// until its last beat is written; wfull stalls the burst without losing it.
//
// Ports:
//   wclk       write clock, rising edge
//   wrst       synchronous active-high reset
//   bus        fifo_wr_arb_if.slave (producer handshakes + memory write port)
//   grant_oh   registered one-hot grant, zero when idle
//   busy       high while a packet burst is in progress
//   pkt_cnt    packets completed since reset, wraps
//   fsm_state  current FSM state (0 = IDLE, 1 = BURST) for observation
module fifo_wr_arb #(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    fifo_wr_arb_if.slave         bus,
    output logic [NUM_REQ-1:0]   grant_oh,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 fsm_state
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      g_idx;    // binary copy of grant_oh for the muxes
    logic [IDX_W-1:0]      rr_last;  // last producer whose packet completed
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic                  sel_valid;
    logic                  sel_last;
    logic [FIFO_WIDTH-1:0] sel_data;
    logic                  accept;

    // Round-robin search starting just after the last completed producer,
    // so that producer has lowest priority next time.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_last) + k) % NUM_REQ;
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Muxes driven by the registered grant index only.
    assign sel_valid = bus.req_valid[g_idx];
    assign sel_last  = bus.req_last[g_idx];
    assign sel_data  = bus.req_data[int'(g_idx)*FIFO_WIDTH +: FIFO_WIDTH];

    // A beat moves only in BURST, with the granted producer valid and room
    // in the FIFO. The reset cycle itself never moves a beat.
    assign accept = (state == BURST) && sel_valid && !bus.wfull && !wrst;

    assign bus.winc      = accept;
    assign bus.req_ready = ((state == BURST) && !bus.wfull && !wrst) ? grant_oh : '0;
    assign bus.wdata     = (state == BURST) ? sel_data : '0;
    assign busy          = (state == BURST);
    assign fsm_state     = state;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            grant_oh <= '0;
            g_idx    <= '0;
            rr_last  <= IDX_W'(NUM_REQ - 1);
            pkt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Grant only; the first beat moves in the next cycle.
                    if (win_found) begin
                        state    <= BURST;
                        g_idx    <= win_idx;
                        grant_oh <= NUM_REQ'(1) << win_idx;
                    end
                end
                BURST: begin
                    // Stalls (valid low or wfull) simply hold the grant.
                    if (accept && sel_last) begin
                        state    <= IDLE;
                        grant_oh <= '0;
                        rr_last  <= g_idx;
                        pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios with literal expectations, then random
// packet traffic. A behavioural model (owner index, round-robin pointer,
// packet count) predicts every output on every cycle; a second instance with
// a 4-bit counter checks wrap-around on the same traffic.
module tb_fifo_wr_arb;
    localparam int FW = 8;
    localparam int NR = 4;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arb_if #(.FIFO_WIDTH(FW), .NUM_REQ(NR)) u_if ();
    fifo_wr_arb_if #(.FIFO_WIDTH(FW), .NUM_REQ(NR)) u_if4 ();

    assign u_if4.req_valid = u_if.req_valid;
    assign u_if4.req_last  = u_if.req_last;
    assign u_if4.req_data  = u_if.req_data;
    assign u_if4.wfull     = u_if.wfull;

    logic [NR-1:0] grant_oh, grant_oh4;
    logic          busy, busy4, fsm_state, fsm_state4;
    logic [CW-1:0] pkt_cnt;
    logic [3:0]    pkt_cnt4;

    fifo_wr_arb #(.FIFO_WIDTH(FW), .NUM_REQ(NR), .CNT_WIDTH(CW)) u_dut (
        .wclk(wclk), .wrst(wrst), .bus(u_if.slave),
        .grant_oh(grant_oh), .busy(busy), .pkt_cnt(pkt_cnt), .fsm_state(fsm_state)
    );

    fifo_wr_arb #(.FIFO_WIDTH(FW), .NUM_REQ(NR), .CNT_WIDTH(4)) u_dut4 (
        .wclk(wclk), .wrst(wrst), .bus(u_if4.slave),
        .grant_oh(grant_oh4), .busy(busy4), .pkt_cnt(pkt_cnt4), .fsm_state(fsm_state4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int          m_owner;   // -1 when no packet in progress
    int          m_last;
    int unsigned m_cnt;
    logic [FW-1:0] exp_q[$];

    task automatic model_update();
        bit found;
        int c;
        if (wrst) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_cnt   = 0;
            exp_q.delete();
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!found && u_if.req_valid[c]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
        end else if (u_if.req_valid[m_owner] && !u_if.wfull && u_if.req_last[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_cnt++;
        end
    endtask

    task automatic model_compare();
        logic [NR-1:0] e_grant, e_ready;
        logic          e_winc;
        logic [FW-1:0] e_wdata, got;
        e_grant = '0; e_ready = '0; e_winc = 1'b0; e_wdata = '0;
        if (m_owner >= 0) begin
            e_grant = NR'(1) << m_owner;
            e_ready = (wrst || u_if.wfull) ? '0 : e_grant;
            e_winc  = u_if.req_valid[m_owner] && !u_if.wfull && !wrst;
            e_wdata = u_if.req_data[m_owner*FW +: FW];
        end
        check("m_grant_oh", grant_oh, e_grant);
        check("m_busy", busy, m_owner >= 0);
        check("m_req_ready", u_if.req_ready, e_ready);
        check("m_winc", u_if.winc, e_winc);
        check("m_wdata", u_if.wdata, e_wdata);
        check("m_pkt_cnt", pkt_cnt, CW'(m_cnt));
        check("m_pkt_cnt4", pkt_cnt4, m_cnt[3:0]);
        if (e_winc) exp_q.push_back(e_wdata);
        if (u_if.winc === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                got = exp_q.pop_front();
                check("sb_wdata", u_if.wdata, got);
            end
        end
    endtask

    initial begin
        @(posedge wclk);
        model_update();
        forever begin
            @(negedge wclk);
            model_compare();
            @(posedge wclk);
            model_update();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic look();
        @(negedge wclk);
    endtask

    task automatic set_prod(input int i, input bit v, input bit l, input logic [FW-1:0] d);
        u_if.req_valid[i]        = v;
        u_if.req_last[i]         = l;
        u_if.req_data[i*FW +: FW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) set_prod(i, 0, 0, '0);
    endtask

    logic [FW-1:0] pq_d[NR][$];
    bit            pq_l[NR][$];

    initial begin
        logic [NR-1:0] acc;
        bit            rst_seen;
        int            len;

        wrst = 1'b1;
        u_if.req_valid = '0;
        u_if.req_last  = '0;
        u_if.req_data  = '0;
        u_if.wfull     = 1'b0;
        tick();
        tick();

        // Reset values, then all four producers offering single-beat packets.
        wrst = 1'b0;
        for (int i = 0; i < NR; i++) set_prod(i, 1, 1, FW'(8'h10 + i));
        look();
        check("rst_grant", grant_oh, 0);
        check("rst_busy", busy, 0);
        check("rst_winc", u_if.winc, 0);
        check("rst_ready", u_if.req_ready, 0);
        check("rst_wdata", u_if.wdata, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);

        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 9) clear_all();
            look();
            if (c % 2 == 0) begin
                check("rr_grant", grant_oh, 32'(1 << ((c / 2) % 4)));
                check("rr_winc", u_if.winc, 1);
                check("rr_wdata", u_if.wdata, 32'(8'h10 + (c / 2) % 4));
            end else begin
                check("rr_bubble_grant", grant_oh, 0);
                check("rr_bubble_winc", u_if.winc, 0);
            end
            check("rr_pkt_cnt", pkt_cnt, 32'((c + 1) / 2));
        end

        // Burst hold: producer 2 sends A0..A3 while producer 1 waits.
        tick();
        set_prod(2, 1, 0, 8'hA0);
        look();
        check("hold_idle", busy, 0);
        tick();
        set_prod(1, 1, 1, 8'h55);
        look();
        check("hold_grant", grant_oh, 4'b0100);
        check("hold_ready", u_if.req_ready, 4'b0100);
        check("hold_wdata", u_if.wdata, 8'hA0);
        for (int b = 1; b < 4; b++) begin
            tick();
            set_prod(2, 1, b == 3, FW'(8'hA0 + b));
            look();
            check("hold_grant", grant_oh, 4'b0100);
            check("hold_winc", u_if.winc, 1);
            check("hold_wdata", u_if.wdata, 32'(8'hA0 + b));
        end
        tick();
        set_prod(2, 0, 0, '0);
        look();
        check("hold_bubble_winc", u_if.winc, 0);
        check("hold_pkt_cnt", pkt_cnt, 6);
        tick();
        look();
        check("hold_next_grant", grant_oh, 4'b0010);
        check("hold_next_wdata", u_if.wdata, 8'h55);
        tick();
        set_prod(1, 0, 0, '0);
        look();
        check("hold_pkt_cnt2", pkt_cnt, 7);

        // Backpressure: wfull for 3 cycles in the middle of a 3-beat packet.
        tick();
        set_prod(3, 1, 0, 8'hC0);
        look();
        tick();
        look();
        check("bp_grant", grant_oh, 4'b1000);
        check("bp_wdata0", u_if.wdata, 8'hC0);
        for (int w = 0; w < 3; w++) begin
            tick();
            set_prod(3, 1, 0, 8'hC1);
            u_if.wfull = 1'b1;
            look();
            check("bp_full_winc", u_if.winc, 0);
            check("bp_full_ready", u_if.req_ready, 0);
            check("bp_full_grant", grant_oh, 4'b1000);
        end
        tick();
        u_if.wfull = 1'b0;
        look();
        check("bp_wdata1", u_if.wdata, 8'hC1);
        check("bp_winc1", u_if.winc, 1);
        tick();
        set_prod(3, 1, 1, 8'hC2);
        look();
        check("bp_wdata2", u_if.wdata, 8'hC2);
        tick();
        set_prod(3, 0, 0, '0);
        look();
        check("bp_pkt_cnt", pkt_cnt, 8);

        // Valid gap: producer 0 drops valid for 2 cycles; 1 and 2 wait.
        tick();
        set_prod(0, 1, 0, 8'hD0);
        set_prod(1, 1, 1, 8'h61);
        set_prod(2, 1, 1, 8'h62);
        look();
        tick();
        look();
        check("gap_grant", grant_oh, 4'b0001);
        check("gap_wdata0", u_if.wdata, 8'hD0);
        for (int g = 0; g < 2; g++) begin
            tick();
            set_prod(0, 0, 0, 8'hD1);
            look();
            check("gap_hold_grant", grant_oh, 4'b0001);
            check("gap_hold_winc", u_if.winc, 0);
        end
        tick();
        set_prod(0, 1, 0, 8'hD1);
        look();
        check("gap_wdata1", u_if.wdata, 8'hD1);
        tick();
        set_prod(0, 1, 1, 8'hD2);
        look();
        check("gap_wdata2", u_if.wdata, 8'hD2);
        check("gap_grant_end", grant_oh, 4'b0001);
        tick();
        set_prod(0, 0, 0, '0);
        look();
        check("gap_pkt_cnt", pkt_cnt, 9);
        tick();
        look();
        check("gap_next_grant", grant_oh, 4'b0010);
        tick();
        clear_all();
        look();
        check("gap_pkt_cnt2", pkt_cnt, 10);

        // Reset in the middle of a 5-beat packet.
        tick();
        set_prod(3, 1, 0, 8'hE0);
        look();
        tick();
        look();
        check("mr_grant", grant_oh, 4'b1000);
        tick();
        set_prod(3, 1, 0, 8'hE1);
        look();
        check("mr_wdata1", u_if.wdata, 8'hE1);
        tick();
        set_prod(3, 1, 0, 8'hE2);
        wrst = 1'b1;
        look();
        check("mr_rst_winc", u_if.winc, 0);
        check("mr_rst_ready", u_if.req_ready, 0);
        tick();
        wrst = 1'b0;
        set_prod(3, 1, 0, 8'hE0);
        set_prod(0, 1, 1, 8'h70);
        look();
        check("mr_after_grant", grant_oh, 0);
        check("mr_after_busy", busy, 0);
        check("mr_after_pkt_cnt", pkt_cnt, 0);
        tick();
        look();
        check("mr_first_grant", grant_oh, 4'b0001);
        check("mr_first_wdata", u_if.wdata, 8'h70);
        tick();
        clear_all();
        look();
        check("mr_pkt_cnt", pkt_cnt, 1);

        // 16 more single-beat packets: 17 since reset, 4-bit counter reads 1.
        tick();
        for (int i = 0; i < NR; i++) set_prod(i, 1, 1, FW'(8'h80 + i));
        look();
        for (int c = 0; c < 32; c++) begin
            tick();
            if (c == 31) clear_all();
            look();
        end
        check("wrap_pkt_cnt", pkt_cnt, 17);
        check("wrap_pkt_cnt4", pkt_cnt4, 1);

        // Random traffic against the model.
        acc      = '0;
        rst_seen = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (rst_seen) begin
                    pq_d[i].delete();
                    pq_l[i].delete();
                end else if (acc[i] && pq_d[i].size() > 0) begin
                    void'(pq_d[i].pop_front());
                    void'(pq_l[i].pop_front());
                end
                if (pq_d[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        pq_d[i].push_back(FW'($urandom));
                        pq_l[i].push_back(b == len - 1);
                    end
                end
            end
            wrst       = ($urandom_range(0, 299) == 0);
            u_if.wfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) begin
                if (pq_d[i].size() > 0 && $urandom_range(0, 4) != 0)
                    set_prod(i, 1, pq_l[i][0], pq_d[i][0]);
                else
                    set_prod(i, 0, 0, FW'($urandom));
            end
            look();
            acc      = u_if.req_valid & u_if.req_ready;
            rst_seen = wrst;
        end

        tick();
        wrst = 1'b0;
        u_if.wfull = 1'b0;
        clear_all();
        look();
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter sharing the single write port of the FIFO memory among NUM_REQ producers in the write-clock domain. Each producer offers packets over a valid/ready/last handshake. The arbiter grants one producer per packet and holds the grant until that packet's last beat is written. It drives winc/wdata to the memory and honours wfull; write-address generation stays with the existing write-pointer logic, which consumes winc.

## Interface
- FIFO_WIDTH, 8, data word width; matches the memory word width.
- NUM_REQ, 4, number of producers; 2..16.
- CNT_WIDTH, 16, width of the completed-packet counter.
- wclk  in  1  write clock; all logic is on the rising edge.
- wrst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_last  in  NUM_REQ  per-producer beat is the last beat of its packet.
- req_data  in  NUM_REQ*FIFO_WIDTH  flattened data; producer i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  per-producer beat accepted this cycle when valid&ready.
- wfull  in  1  FIFO full flag from the write-pointer logic.
- winc  out  1  memory write enable / write-pointer increment.
- wdata  out  FIFO_WIDTH  write data to memory.
- grant_oh  out  NUM_REQ  registered one-hot grant; all zeros when idle.
- busy  out  1  high while in BURST.
- pkt_cnt  out  CNT_WIDTH  number of packets completed since reset; wraps.

## Operation
- Two-state FSM, IDLE and BURST. State, grant register, round-robin pointer rr_last (index of last granted producer) and pkt_cnt are all registered.
- IDLE: req_ready = 0, winc = 0, grant_oh = 0.
  - If any req_valid is high, select the first valid producer searching from (rr_last+1) mod NUM_REQ upward with wrap.
  - Load grant_oh with the winner and go to BURST. No beat is transferred in this cycle.
- BURST, with granted index g:
  - req_ready[g] = !wfull; all other req_ready bits = 0.
  - winc = req_valid[g] & !wfull.
  - wdata = req_data[g] (combinational mux on the registered grant).
- Beat accepted with req_last[g] = 1:
  - Next state is IDLE, rr_last <= g, grant_oh <= 0.
  - pkt_cnt increments by 1, modulo 2^CNT_WIDTH.
- Beat accepted with req_last[g] = 0: stay in BURST with the same grant.
- req_valid[g] low in BURST: hold the grant, no write. A stalled packet is never pre-empted.
- wfull high: no write and no ready. Grant and state are held and the beat is retried when wfull falls. winc is never asserted while wfull = 1.
- Valid or last on non-granted producers is ignored during BURST; those producers wait.
- Single-beat packet (last on the first beat): BURST lasts exactly one accepting cycle.
- Non-granted producers are not starved. After any packet from g completes, g has lowest priority in the next arbitration.

## Timing
- Reset values: state IDLE, grant_oh 0, busy 0, req_ready 0, winc 0, wdata 0 (mux forced to zero when idle), pkt_cnt 0, rr_last NUM_REQ-1 (producer 0 wins first).
- Arbitration latency: a valid in IDLE at edge N gives grant_oh/busy at N+1, and the first beat can be written in cycle N+1.
- Throughput: one beat per cycle within a packet; one idle bubble cycle between packets.
- winc, req_ready and wdata are combinational from registered grant plus req_valid, req_data and wfull. No registered output is stale.
- wrst asserted mid-burst: on the next edge everything returns to reset values and the partial packet is abandoned. Producers must restart it. In the wrst cycle itself, req_ready and winc are forced to 0.
- pkt_cnt and grant update on the same edge as the last-beat write.

## Test plan
- Reset/first grant: wrst for 2 cycles, then req_valid = 4'b1111, all single-beat packets -> grants in order 0,1,2,3,0, each with grant_oh one-hot, one winc per 2 cycles, pkt_cnt reaches 5.
- Burst hold: producer 2 sends 4 beats 0xA0..0xA3 (last on 0xA3) while producer 1 is valid throughout -> wdata sequence A0,A1,A2,A3 on 4 consecutive winc cycles, then 1 idle cycle, then grant_oh = 4'b0010.
- Backpressure: wfull high for 3 cycles in the middle of a 3-beat packet -> winc = 0 and req_ready = 0 during those cycles, grant held, no beat lost or duplicated, pkt_cnt +1 at the end.
- Valid gap: granted producer drops valid for 2 cycles mid-packet while others are valid -> grant unchanged, winc = 0 during the gap, and the packet completes before any other grant.
- Reset mid-burst: assert wrst on beat 2 of 5 -> next cycle grant_oh = 0, busy = 0, pkt_cnt = 0, and the next grant goes to producer 0.
- Counter wrap with CNT_WIDTH = 4: 17 single-beat packets -> pkt_cnt reads 1.
